// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (fetch / load-store) arbiter in front of one
//            single-port memory. Data requests win by default; a pending
//            fetch is forced through after STARVE_LIMIT consecutive data
//            grants.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam logic [1:0] c_idle       = 2'd0;
  localparam logic [1:0] c_busy       = 2'd1;
  localparam logic [1:0] c_resp       = 2'd2;
  localparam logic       c_own_data   = 1'b0;
  localparam logic       c_own_fetch  = 1'b1;
  localparam logic [3:0] c_starve_lim = 4'(STARVE_LIMIT);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_owner;
  logic [3:0]        r_starve_cnt;
  logic              w_grant;
  logic              w_grant_fetch;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  // State register: reset abandons any in-flight transaction
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_next_state;
  end

  // Next-state and grant decision; the fetch port only wins a tie once
  // the data port has used up its starvation allowance
  always_comb begin
    w_next_state  = r_state;
    w_grant       = 1'b0;
    w_grant_fetch = 1'b0;
    case (r_state)
      c_idle: begin
        if (d_req || if_req) begin
          w_grant       = 1'b1;
          w_grant_fetch = if_req && (!d_req || (r_starve_cnt == c_starve_lim));
          w_next_state  = c_busy;
        end
      end
      c_busy:  if (mem_ready) w_next_state = c_resp;
      c_resp:  w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // Outputs decoded from the current state and owner
  always_comb begin
    busy    = (r_state != c_idle);
    mem_req = (r_state == c_busy);
    if_ack  = (r_state == c_resp) && (r_owner == c_own_fetch);
    d_ack   = (r_state == c_resp) && (r_owner == c_own_data);
  end

  // Datapath: capture the granted request, track starvation, load read data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= c_own_data;
      r_starve_cnt <= 4'd0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      if (w_grant) begin
        if (w_grant_fetch) begin
          r_owner      <= c_own_fetch;
          r_mem_we     <= 1'b0;
          r_mem_addr   <= if_addr;
          r_starve_cnt <= 4'd0;
        end else begin
          r_owner     <= c_own_data;
          r_mem_we    <= d_we;
          r_mem_addr  <= d_addr;
          r_mem_wdata <= d_wdata;
          if (if_req && (r_starve_cnt != c_starve_lim))
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end
      if ((r_state == c_busy) && mem_ready) begin
        if (r_owner == c_own_fetch) r_if_rdata <= mem_rdata;
        else if (!r_mem_we)         r_d_rdata  <= mem_rdata;
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, 32: data bus width.
REQ-002 Parameter ADDR_W, 32: address bus width.
REQ-003 Parameter STARVE_LIMIT, 3: consecutive data grants with fetch pending before fetch is forced; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 if_req  input  1  fetch request, held until if_ack.
REQ-007 if_addr  input  ADDR_W  fetch address, stable while if_req high.
REQ-008 if_rdata  output  DATA_W  registered fetch data.
REQ-009 if_ack  output  1  one-cycle fetch completion pulse.
REQ-010 d_req  input  1  load/store request, held until d_ack.
REQ-011 d_we  input  1  1 = store, 0 = load; stable while d_req high.
REQ-012 d_addr  input  ADDR_W  load/store address.
REQ-013 d_wdata  input  DATA_W  store data.
REQ-014 d_rdata  output  DATA_W  registered load data.
REQ-015 d_ack  output  1  one-cycle load/store completion pulse.
REQ-016 mem_req  output  1  request to the single-port memory.
REQ-017 mem_we  output  1  memory write enable.
REQ-018 mem_addr  output  ADDR_W  memory address.
REQ-019 mem_wdata  output  DATA_W  memory write data.
REQ-020 mem_rdata  input  DATA_W  memory read data, valid when mem_ready high.
REQ-021 mem_ready  input  1  memory completion, sampled only while mem_req high.
REQ-022 busy  output  1  high in any state other than IDLE.

Function
REQ-023 FSM states: IDLE, BUSY, RESP; one owner register (FETCH/DATA) records the granted port.
REQ-024 IDLE: d_req only -> grant DATA; if_req only -> grant FETCH; neither -> stay IDLE.
REQ-025 IDLE, both requests: grant DATA, unless starve_cnt == STARVE_LIMIT, then grant FETCH.
REQ-026 On grant edge: mem_addr/mem_we/mem_wdata registered from granted port (mem_we = 0, mem_wdata unchanged for fetch); mem_req = 1; state -> BUSY.
REQ-027 BUSY: mem_req and mem_* outputs held constant; mem_ready = 0 -> stay BUSY (unbounded wait states).
REQ-028 BUSY, mem_ready = 1: mem_req = 0 next cycle; state -> RESP; owner's rdata register loads mem_rdata on loads/fetches only; stores leave d_rdata unchanged.
REQ-029 RESP: owner's ack = 1 for exactly this cycle; requests ignored; state -> IDLE unconditionally.
REQ-030 if_rdata/d_rdata hold their value until the next completing read on that port.
REQ-031 Minimum latency with zero-wait memory: req seen in IDLE at cycle N -> mem_req high cycle N+1 -> ack high cycle N+2; next grant earliest cycle N+3.
REQ-032 starve_cnt: +1 (saturating at STARVE_LIMIT) on each DATA grant while if_req = 1; cleared on FETCH grant; unchanged on DATA grant with if_req = 0.
REQ-033 Never both acks in one cycle; never a second mem_req before the previous mem_ready.
REQ-034 A request deasserted before its grant is dropped without side effects (protocol violation, no error flagged).

Reset
REQ-035 rst sampled high: state = IDLE, owner = DATA, starve_cnt = 0, all outputs 0 (including rdata registers) from the following cycle.
REQ-036 rst during BUSY or RESP: transaction abandoned, no ack issued, mem_req low the cycle after the reset edge; pending mem_ready ignored.

Verification
REQ-037 Single load: d_req, d_addr=0x40, mem_ready on 1st BUSY cycle, mem_rdata=0x1234ABCD -> d_ack pulse 2 cycles after request, d_rdata=0x1234ABCD, if_ack never high.
REQ-038 Simultaneous if_req and d_req from reset -> DATA served first, then FETCH; if_addr=0x0 on mem_addr with mem_we=0 for second transaction.
REQ-039 Starvation: d_req and if_req held continuously (d_req reissued after each ack), STARVE_LIMIT=3 -> grant order D,D,D,F,D,D,D,F.
REQ-040 Store with 3 wait states: d_we=1, d_wdata=0xDEADBEEF -> mem_req high 4 cycles, mem_we=1 throughout, d_ack after, d_rdata unchanged.
REQ-041 rst asserted in 2nd BUSY cycle of a fetch -> no if_ack, mem_req=0 next cycle, busy=0, if_rdata=0.
REQ-042 Back-to-back fetches with zero-wait memory -> if_ack every 3 cycles, busy low one cycle between transactions.
